// File: rtl/updown_counter_mod_pkg.sv
// ============================================================================
//  Module  : updown_counter_mod_pkg
//  Brief   : Shared encodings and helpers for the modulo-M up/down counter.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package updown_counter_mod_pkg;

    // Boundary-mode encodings for the sat input.
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Resolved per-edge operation after clear > load > enable priority.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_CLEAR = 2'd1,
        OP_LOAD  = 2'd2,
        OP_COUNT = 2'd3
    } op_e;

    // Legal modulus range check without $clog2: 2 <= m <= 2**n.
    function automatic bit modulus_ok(input int n, input int m);
        return (m >= 2) && (m <= (1 << n));
    endfunction

endpackage : updown_counter_mod_pkg

`default_nettype wire

// File: rtl/updown_counter_next.sv
// ============================================================================
//  Module  : updown_counter_next
//  Brief   : Combinational next-state, event and terminal-count logic.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module updown_counter_next
    import updown_counter_mod_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 16
) (
    input  logic [N-1:0] i_q,
    input  logic         i_up,
    input  logic         i_sat,
    input  logic         i_enable,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q_next,
    output logic         o_wrap_ev,
    output logic         o_sat_ev,
    output logic         o_tc
);

    // Bound kept at N bits so M = 2**N never needs an (N+1)-bit compare.
    localparam logic [N-1:0] c_MAX  = N'(M - 1);
    localparam logic [N-1:0] c_ZERO = '0;
    localparam logic [N-1:0] c_ONE  = N'(1);

    op_e  w_op;
    logic w_at_max;
    logic w_at_zero;
    logic w_at_bound;

    assign w_at_max   = (i_q == c_MAX);
    assign w_at_zero  = (i_q == c_ZERO);
    assign w_at_bound = i_up ? w_at_max : w_at_zero;

    always_comb begin
        w_op = OP_HOLD;
        if (i_clear) begin
            w_op = OP_CLEAR;
        end else if (i_load) begin
            w_op = OP_LOAD;
        end else if (i_enable) begin
            w_op = OP_COUNT;
        end
    end

    always_comb begin
        o_q_next  = i_q;
        o_wrap_ev = 1'b0;
        o_sat_ev  = 1'b0;
        case (w_op)
            OP_CLEAR: o_q_next = c_ZERO;
            OP_LOAD:  o_q_next = (i_d > c_MAX) ? c_MAX : i_d;
            OP_COUNT: begin
                if (!w_at_bound) begin
                    o_q_next = i_up ? (i_q + c_ONE) : (i_q - c_ONE);
                end else if (i_sat == MODE_SAT) begin
                    o_sat_ev = 1'b1;
                end else begin
                    o_q_next  = i_up ? c_ZERO : c_MAX;
                    o_wrap_ev = 1'b1;
                end
            end
            default: o_q_next = i_q;
        endcase
    end

    // Carry/borrow for cascading; deliberately blind to the boundary mode.
    assign o_tc = (w_op == OP_COUNT) && w_at_bound;

endmodule : updown_counter_next

`default_nettype wire

// File: rtl/updown_counter_mod.sv
// ============================================================================
//  Module  : updown_counter_mod
//  Brief   : Modulo-M up/down counter with clear, load, wrap/saturate mode,
//            cascade terminal count and wrap/saturation status.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module updown_counter_mod
    import updown_counter_mod_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         up,
    input  logic         sat,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] Q,
    output logic         tc,
    output logic         wrapped,
    output logic         sat_hit
);

    generate
        if (!modulus_ok(N, M)) begin : g_bad_modulus
            $error("updown_counter_mod: M=%0d outside 2..2**N for N=%0d", M, N);
        end
    endgenerate

    logic [N-1:0] r_q;
    logic         r_wrapped;
    logic         r_sat_hit;
    logic [N-1:0] w_q_next;
    logic         w_wrap_ev;
    logic         w_sat_ev;

    updown_counter_next #(
        .N (N),
        .M (M)
    ) u_next (
        .i_q       (r_q),
        .i_up      (up),
        .i_sat     (sat),
        .i_enable  (enable),
        .i_clear   (clear),
        .i_load    (load),
        .i_d       (d),
        .o_q_next  (w_q_next),
        .o_wrap_ev (w_wrap_ev),
        .o_sat_ev  (w_sat_ev),
        .o_tc      (tc)
    );

    // wrapped is a pure one-cycle pulse; sat_hit is sticky until clear/reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q       <= '0;
            r_wrapped <= 1'b0;
            r_sat_hit <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_wrapped <= w_wrap_ev;
            if (clear) begin
                r_sat_hit <= 1'b0;
            end else if (w_sat_ev) begin
                r_sat_hit <= 1'b1;
            end
        end
    end

    assign Q       = r_q;
    assign wrapped = r_wrapped;
    assign sat_hit = r_sat_hit;

endmodule : updown_counter_mod

`default_nettype wire

// File: tb/tb_updown_counter_mod.sv
// ============================================================================
//  Module  : tb_updown_counter_mod
//  Brief   : Self-checking bench: directed vector table, reset/cascade
//            sequences and randomized run against a behavioural model.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable, up, sat, clear, load;
    logic [3:0] d;

    logic [3:0] q10, q16;
    logic       tc10, wr10, sh10, tc16, wr16, sh16;

    logic       c_en, c_up, c_clear;
    logic [3:0] c0q, c1q;
    logic       c0tc, c0wr, c0sh, c1tc, c1wr, c1sh;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    updown_counter_mod #(.N(4), .M(10)) dut10 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .sat(sat),
        .clear(clear), .load(load), .d(d),
        .Q(q10), .tc(tc10), .wrapped(wr10), .sat_hit(sh10)
    );

    updown_counter_mod #(.N(4), .M(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .sat(sat),
        .clear(clear), .load(load), .d(d),
        .Q(q16), .tc(tc16), .wrapped(wr16), .sat_hit(sh16)
    );

    updown_counter_mod #(.N(4), .M(10)) cas0 (
        .clk(clk), .reset_n(reset_n), .enable(c_en), .up(c_up), .sat(1'b0),
        .clear(c_clear), .load(1'b0), .d(4'd0),
        .Q(c0q), .tc(c0tc), .wrapped(c0wr), .sat_hit(c0sh)
    );

    updown_counter_mod #(.N(4), .M(10)) cas1 (
        .clk(clk), .reset_n(reset_n), .enable(c0tc), .up(c_up), .sat(1'b0),
        .clear(c_clear), .load(1'b0), .d(4'd0),
        .Q(c1q), .tc(c1tc), .wrapped(c1wr), .sat_hit(c1sh)
    );

    typedef struct {
        logic       en, up, sat, clr, ld;
        logic [3:0] d;
        logic       e_tc;
        logic [3:0] e_q;
        logic       e_wr, e_sh;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic en, input logic u, input logic s,
                                input logic clr, input logic ld, input logic [3:0] dv,
                                input logic etc, input logic [3:0] eq,
                                input logic ewr, input logic esh);
        vec_t v;
        v.en = en; v.up = u; v.sat = s; v.clr = clr; v.ld = ld; v.d = dv;
        v.e_tc = etc; v.e_q = eq; v.e_wr = ewr; v.e_sh = esh;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        enable = v.en; up = v.up; sat = v.sat; clear = v.clr; load = v.ld; d = v.d;
        #1;
        check($sformatf("vec%0d.tc", idx), int'(tc10), int'(v.e_tc));
        @(posedge clk); #1;
        check($sformatf("vec%0d.Q", idx), int'(q10), int'(v.e_q));
        check($sformatf("vec%0d.wrapped", idx), int'(wr10), int'(v.e_wr));
        check($sformatf("vec%0d.sat_hit", idx), int'(sh10), int'(v.e_sh));
    endtask

    // Reference: the count lives on the integer line 0..m-1; stepping off
    // either end either wraps (modulo m) or is refused and recorded.
    task automatic ref_step(input int m, input bit en, input bit u, input bit s,
                            input bit clr, input bit ld, input int dv,
                            inout int q, inout bit wr, inout bit sh, output bit tcx);
        int tgt;
        tgt = u ? q + 1 : q - 1;
        tcx = en && !clr && !ld && (tgt < 0 || tgt > m - 1);
        wr  = 1'b0;
        if (clr) begin
            q = 0; sh = 1'b0;
        end else if (ld) begin
            q = (dv < m - 1) ? dv : m - 1;
        end else if (en) begin
            if (tgt >= 0 && tgt <= m - 1) q = tgt;
            else if (s) sh = 1'b1;
            else begin q = (tgt + m) % m; wr = 1'b1; end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int  mq10, mq16;
        bit  mw10, ms10, mw16, ms16, mt10, mt16;
        bit  r_en, r_up, r_sat, r_clr, r_ld;
        int  r_d, v_old, v_new;

        reset_n = 1'b0; enable = 0; up = 0; sat = 0; clear = 0; load = 0; d = 0;
        c_en = 0; c_up = 1; c_clear = 0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset.Q", int'(q10), 0);
        check("reset.wrapped", int'(wr10), 0);
        check("reset.sat_hit", int'(sh10), 0);
        check("reset.tc", int'(tc10), 0);
        reset_n = 1'b1;

        // Free-running up count with wrap.
        for (int i = 0; i < 12; i++)
            tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1'((i % 10) == 9), 4'((i + 1) % 10),
                             1'(((i + 1) % 10) == 0), 0));
        // Down from 0 wraps to M-1.
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 9, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 7, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 6, 0, 0));
        // Saturate at top, sticky sat_hit, clear.
        tbl.push_back(mk(0, 1, 1, 0, 1, 8, 0, 8, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 9, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 9, 0, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 9, 0, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 9, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        // Load clamp and priority.
        tbl.push_back(mk(0, 1, 0, 0, 1, 15, 0, 9, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 3, 0, 3, 0, 0));
        // Saturate at bottom; load keeps sat_hit; wrapped cleared by idle and load.
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 1, 5, 0, 5, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 6, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 9, 0, 9, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 9, 0, 9, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 4, 0, 4, 0, 1));
        // Set up Q=5 with sat_hit high for the async reset check.
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 5, 0, 5, 0, 1));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Asynchronous reset between edges.
        enable = 1; up = 1; sat = 0; clear = 0; load = 0; d = 0;
        #3;
        reset_n = 1'b0;
        #1;
        check("async.Q", int'(q10), 0);
        check("async.sat_hit", int'(sh10), 0);
        check("async.wrapped", int'(wr10), 0);
        @(posedge clk); #1;
        check("async.hold", int'(q10), 0);
        enable = 0;
        reset_n = 1'b1;

        // Two-digit decimal cascade, up then down.
        c_en = 1; c_up = 1;
        for (int k = 1; k <= 100; k++) begin
            v_old = k - 1;
            #1;
            check($sformatf("cas_up%0d.tc1", k), int'(c1tc), int'(v_old == 99));
            @(posedge clk); #1;
            v_new = k % 100;
            check($sformatf("cas_up%0d.val", k), int'(c1q) * 10 + int'(c0q), v_new);
            check($sformatf("cas_up%0d.wr1", k), int'(c1wr), int'(k == 100));
            check($sformatf("cas_up%0d.wr0", k), int'(c0wr), int'(v_new % 10 == 0));
        end
        c_up = 0;
        for (int k = 1; k <= 100; k++) begin
            v_old = (100 - (k - 1)) % 100;
            #1;
            check($sformatf("cas_dn%0d.tc1", k), int'(c1tc), int'(v_old == 0));
            @(posedge clk); #1;
            v_new = (100 - k) % 100;
            check($sformatf("cas_dn%0d.val", k), int'(c1q) * 10 + int'(c0q), v_new);
            check($sformatf("cas_dn%0d.wr1", k), int'(c1wr), int'(k == 1));
            check($sformatf("cas_dn%0d.wr0", k), int'(c0wr), int'(v_new % 10 == 9));
        end
        c_en = 0;
        check("cas.sat_hit0", int'(c0sh), 0);
        check("cas.sat_hit1", int'(c1sh), 0);

        // Randomized run on M=10 and M=16 (full-range modulus) together.
        clear = 1; enable = 0; load = 0;
        @(posedge clk); #1;
        clear = 0;
        mq10 = 0; mw10 = 0; ms10 = 0;
        mq16 = 0; mw16 = 0; ms16 = 0;
        for (int i = 0; i < 400; i++) begin
            r_clr = ($urandom_range(0, 15) == 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_up  = 1'($urandom_range(0, 1));
            r_sat = 1'($urandom_range(0, 1));
            r_d   = int'($urandom_range(0, 15));
            enable = r_en; up = r_up; sat = r_sat; clear = r_clr; load = r_ld; d = 4'(r_d);
            ref_step(10, r_en, r_up, r_sat, r_clr, r_ld, r_d, mq10, mw10, ms10, mt10);
            ref_step(16, r_en, r_up, r_sat, r_clr, r_ld, r_d, mq16, mw16, ms16, mt16);
            #1;
            check($sformatf("rnd%0d.tc10", i), int'(tc10), int'(mt10));
            check($sformatf("rnd%0d.tc16", i), int'(tc16), int'(mt16));
            @(posedge clk); #1;
            check($sformatf("rnd%0d.Q10", i), int'(q10), mq10);
            check($sformatf("rnd%0d.wr10", i), int'(wr10), int'(mw10));
            check($sformatf("rnd%0d.sh10", i), int'(sh10), int'(ms10));
            check($sformatf("rnd%0d.Q16", i), int'(q16), mq16);
            check($sformatf("rnd%0d.wr16", i), int'(wr16), int'(mw16));
            check($sformatf("rnd%0d.sh16", i), int'(sh16), int'(ms16));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_updown_counter_mod

`default_nettype wire
